// File: rtl/hi_ram_terminal.sv
// hi_ram_terminal: di_* bus responder backed by a 2**ADDR_WIDTH x 32-bit single-port RAM.
// Optional build macro HI_RAM_TERMINAL_WRAP_ERR_EN: stop with status 3 instead of wrapping the address.
module hi_ram_terminal #(
  parameter logic [15:0] TERM_ADDR  = 16'h0010,
  parameter int          ADDR_WIDTH = 8
) (
  input  logic        ifclk,
  input  logic        reset,
  input  logic [15:0] di_term_addr,
  input  logic [31:0] di_reg_addr,
  input  logic [31:0] di_len,
  input  logic        di_write_mode,
  input  logic        di_write,
  input  logic [31:0] di_reg_datai,
  output logic        di_write_rdy,
  input  logic        di_read_mode,
  input  logic        di_read_req,
  input  logic        di_read,
  output logic        di_read_rdy,
  output logic [31:0] di_reg_datao,
  output logic [15:0] di_transfer_status,
  output logic [2:0]  dbg_state
);

  // Handshakes: a write word moves on a cycle where di_write && di_write_rdy; a read word is
  // consumed on a cycle where di_read && di_read_rdy. Requests while the rdy is low are ignored.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_WAIT  = 3'd2,
    RD_FETCH = 3'd3,
    RD_VALID = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [30:0]             rem_q, rem_d;
  logic [15:0]             status_q, status_d;
  logic                    act_w_q, act_w_d;
  logic                    act_r_q, act_r_d;
  logic                    wm_q, rm_q;
  logic                    mem_we, rd_en;
  logic [31:0]             rd_data;
  logic [31:0]             mem [0:(2**ADDR_WIDTH)-1];

  logic        sel;
  logic        w_rise, r_rise;
  logic        mode_held;
  logic        addr_last;
  logic        write_fire, read_fire;
  logic [30:0] words;

  assign sel        = (di_term_addr == TERM_ADDR);
  assign w_rise     = di_write_mode & ~wm_q;
  assign r_rise     = di_read_mode & ~rm_q;
  // Both-modes error transactions stay alive until every mode that started them is low.
  assign mode_held  = (act_w_q & di_write_mode) | (act_r_q & di_read_mode);
  assign addr_last  = &addr_q;
  assign words      = {1'b0, di_len[31:2]} + {30'd0, |di_len[1:0]};
  assign write_fire = sel & di_write & (state_q == WRITE) & (rem_q != 31'd0);
  assign read_fire  = sel & di_read & (state_q == RD_VALID);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    status_d = status_q;
    act_w_d  = act_w_q;
    act_r_d  = act_r_q;
    mem_we   = 1'b0;
    rd_en    = 1'b0;
    if (state_q != IDLE && !mode_held) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel && (w_rise || r_rise)) begin
            act_w_d  = di_write_mode;
            act_r_d  = di_read_mode;
            addr_d   = di_reg_addr[ADDR_WIDTH-1:0];
            rem_d    = words;
            status_d = 16'h0000;
            if (di_write_mode && di_read_mode) begin
              status_d = 16'h0002;
              state_d  = DONE;
            end else if (di_reg_addr[31:ADDR_WIDTH] != '0) begin
              status_d = 16'h0001;
              state_d  = DONE;
            end else if (di_write_mode) begin
              state_d = WRITE;
            end else begin
              state_d = RD_WAIT;
            end
          end
        end
        WRITE: begin
          if (rem_q == 31'd0) begin
            state_d = DONE;
          end else if (write_fire) begin
            mem_we = 1'b1;
            addr_d = addr_q + 1'b1;
            rem_d  = rem_q - 31'd1;
            if (rem_q == 31'd1) state_d = DONE;
`ifdef HI_RAM_TERMINAL_WRAP_ERR_EN
            if (addr_last) begin
              status_d = 16'h0003;
              state_d  = DONE;
            end
`endif
          end
        end
        RD_WAIT: begin
          if (sel && di_read_req) state_d = (rem_q == 31'd0) ? DONE : RD_FETCH;
        end
        RD_FETCH: begin
          rd_en   = 1'b1;
          state_d = RD_VALID;
        end
        RD_VALID: begin
          if (read_fire) begin
            addr_d  = addr_q + 1'b1;
            rem_d   = rem_q - 31'd1;
            state_d = (rem_q > 31'd1) ? RD_FETCH : DONE;
`ifdef HI_RAM_TERMINAL_WRAP_ERR_EN
            if (addr_last) begin
              status_d = 16'h0003;
              state_d  = DONE;
            end
`endif
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      status_q <= '0;
      act_w_q  <= 1'b0;
      act_r_q  <= 1'b0;
      wm_q     <= 1'b0;
      rm_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      status_q <= status_d;
      act_w_q  <= act_w_d;
      act_r_q  <= act_r_d;
      wm_q     <= di_write_mode;
      rm_q     <= di_read_mode;
    end
  end

  // RAM contents and the read register are deliberately left out of reset.
  always_ff @(posedge ifclk) begin
    if (mem_we) mem[addr_q] <= di_reg_datai;
    if (rd_en) rd_data <= mem[addr_q];
  end

  assign di_write_rdy       = sel & (state_q == WRITE) & (rem_q != 31'd0);
  assign di_read_rdy        = sel & (state_q == RD_VALID);
  assign di_reg_datao       = (sel && state_q == RD_VALID) ? rd_data : 32'd0;
  assign di_transfer_status = sel ? status_q : 16'd0;
  assign dbg_state          = state_q;

endmodule
